// File: rtl/control_calculadora_teclado.sv
// Keypad calculator sequencer: builds two decimal operands, runs the adder handshake, picks the display value.
// Optional adder watchdog enabled by defining CTRL_TIMEOUT_EN.
module control_calculadora_teclado #(
   parameter int DIGITOS        = 4,
   parameter int ANCHO          = 14,
   parameter int TIMEOUT_CICLOS = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       tecla,
   input  logic             tecla_valida,
   output logic [ANCHO-1:0] operando1,
   output logic [ANCHO-1:0] operando2,
   output logic             suma_inicio,
   input  logic             suma_listo,
   input  logic [ANCHO:0]   suma_resultado,
   output logic [ANCHO:0]   resultado,
   output logic [ANCHO:0]   dato_display,
   output logic             ocupado,
   output logic             error_timeout
);

   localparam int CW = $clog2(DIGITOS + 1);
   localparam logic [CW-1:0] DIG_MAX = CW'(DIGITOS);

   typedef enum logic [2:0] {S_NUM1, S_NUM2, S_INICIO, S_ESPERA, S_RESULT} estado_t;

   estado_t          estado, estado_d;
   logic [ANCHO-1:0] op1_d, op2_d, op_nuevo;
   logic [ANCHO:0]   res_d, disp_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic             es_digito, es_sig, es_igual, es_borrar;
   logic             tmo_fin;

   assign es_digito = tecla_valida && (tecla <= 4'd9);
   assign es_sig    = tecla_valida && (tecla == 4'hA);
   assign es_igual  = tecla_valida && (tecla == 4'hB);
   assign es_borrar = tecla_valida && (tecla == 4'hC);

   // Decimal shift-in of the key into whichever operand is being typed.
   assign op_nuevo = ((estado == S_NUM2) ? operando2 : operando1) * ANCHO'(10) + ANCHO'(tecla);

`ifdef CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CICLOS - 1);
   logic [TW-1:0] tmo_cnt;

   // Counter is held at zero outside S_ESPERA, so every entry starts a fresh window.
   always_ff @(posedge clk) begin
      if (rst || estado != S_ESPERA) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_fin = (estado == S_ESPERA) && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst || es_borrar)              error_timeout <= 1'b0;
      else if (tmo_fin && !suma_listo)   error_timeout <= 1'b1;
   end
`else
   assign tmo_fin       = 1'b0;
   assign error_timeout = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      estado_d = estado;
      op1_d    = operando1;
      op2_d    = operando2;
      res_d    = resultado;
      cnt_d    = cnt;
      disp_d   = '0;

      unique case (estado)
         S_NUM1: begin
            if (es_digito) begin
               if (cnt < DIG_MAX) begin
                  op1_d = op_nuevo;
                  cnt_d = cnt + 1'b1;
               end
            end else if (es_sig) begin
               estado_d = S_NUM2;
               cnt_d    = '0;
            end
         end
         S_NUM2: begin
            if (es_digito) begin
               if (cnt < DIG_MAX) begin
                  op2_d = op_nuevo;
                  cnt_d = cnt + 1'b1;
               end
            end else if (es_igual) begin
               estado_d = S_INICIO;
            end
         end
         S_INICIO: estado_d = S_ESPERA;
         S_ESPERA: begin
            if (suma_listo) begin
               res_d    = suma_resultado;
               estado_d = S_RESULT;
            end else if (tmo_fin) begin
               op1_d    = '0;
               op2_d    = '0;
               cnt_d    = '0;
               estado_d = S_NUM1;
            end
         end
         S_RESULT: begin
            if (es_digito) begin
               op1_d    = ANCHO'(tecla);
               op2_d    = '0;
               res_d    = '0;
               cnt_d    = CW'(1);
               estado_d = S_NUM1;
            end
         end
         default: estado_d = S_NUM1;
      endcase

      // Clear overrides everything, including an adder result arriving in the same cycle.
      if (es_borrar) begin
         op1_d    = '0;
         op2_d    = '0;
         res_d    = '0;
         cnt_d    = '0;
         estado_d = S_NUM1;
      end

      unique case (estado_d)
         S_NUM1:                      disp_d = {1'b0, op1_d};
         S_NUM2, S_INICIO, S_ESPERA:  disp_d = {1'b0, op2_d};
         S_RESULT:                    disp_d = res_d;
         default:                     disp_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         estado       <= S_NUM1;
         operando1    <= '0;
         operando2    <= '0;
         resultado    <= '0;
         cnt          <= '0;
         suma_inicio  <= 1'b0;
         ocupado      <= 1'b0;
         dato_display <= '0;
      end else begin
         estado       <= estado_d;
         operando1    <= op1_d;
         operando2    <= op2_d;
         resultado    <= res_d;
         cnt          <= cnt_d;
         suma_inicio  <= (estado_d == S_INICIO);
         ocupado      <= (estado_d == S_INICIO) || (estado_d == S_ESPERA);
         dato_display <= disp_d;
      end
   end

endmodule

// File: tb/tb_control_calculadora_teclado.sv
// Bench for control_calculadora_teclado: directed scenarios then random keys/adder events vs a reference model.
// Timeout scenario is exercised only when CTRL_TIMEOUT_EN is defined.
module tb_control_calculadora_teclado;

   localparam int DIG = 4;
   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  tecla = '0;
   logic        tecla_valida = 1'b0;
   logic [13:0] operando1, operando2;
   logic        suma_inicio;
   logic        suma_listo = 1'b0;
   logic [14:0] suma_resultado = '0;
   logic [14:0] resultado, dato_display;
   logic        ocupado, error_timeout;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   control_calculadora_teclado dut (
      .clk(clk), .rst(rst), .tecla(tecla), .tecla_valida(tecla_valida),
      .operando1(operando1), .operando2(operando2), .suma_inicio(suma_inicio),
      .suma_listo(suma_listo), .suma_resultado(suma_resultado), .resultado(resultado),
      .dato_display(dato_display), .ocupado(ocupado), .error_timeout(error_timeout)
   );

   always #5 clk = ~clk;

   // Reference model: phases of the calculator flow, operands as plain integers.
   localparam int ENTER_A = 0, ENTER_B = 1, LAUNCH = 2, WAITING = 3, SHOWING = 4;
   int m_phase, m_a, m_b, m_sum, m_digits, m_waited;
   bit m_err;

   function automatic void model_reset();
      m_phase = ENTER_A; m_a = 0; m_b = 0; m_sum = 0; m_digits = 0; m_waited = 0; m_err = 0;
   endfunction

   function automatic void model_step(input bit v, input int k, input bit l, input int r);
      if (v && k == 12) begin
         model_reset();
         return;
      end
      case (m_phase)
         ENTER_A:
            if (v && k <= 9 && m_digits < DIG) begin m_a = m_a * 10 + k; m_digits++; end
            else if (v && k == 10) begin m_phase = ENTER_B; m_digits = 0; end
         ENTER_B:
            if (v && k <= 9 && m_digits < DIG) begin m_b = m_b * 10 + k; m_digits++; end
            else if (v && k == 11) m_phase = LAUNCH;
         LAUNCH: begin m_phase = WAITING; m_waited = 0; end
         WAITING:
            if (l) begin m_sum = r; m_phase = SHOWING; end
            else begin
`ifdef CTRL_TIMEOUT_EN
               m_waited++;
               if (m_waited == TMO) begin
                  m_err = 1; m_a = 0; m_b = 0; m_digits = 0; m_phase = ENTER_A;
               end
`endif
            end
         SHOWING:
            if (v && k <= 9) begin
               m_a = k; m_b = 0; m_sum = 0; m_digits = 1; m_phase = ENTER_A;
            end
         default: ;
      endcase
   endfunction

   task automatic chk(input string tag, input string sig, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s.%s got=%0d exp=%0d", tag, sig, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int disp;
      disp = (m_phase == ENTER_A) ? m_a : (m_phase == SHOWING) ? m_sum : m_b;
      chk(tag, "operando1", 32'(operando1), 32'(m_a));
      chk(tag, "operando2", 32'(operando2), 32'(m_b));
      chk(tag, "resultado", 32'(resultado), 32'(m_sum));
      chk(tag, "dato_display", 32'(dato_display), 32'(disp));
      chk(tag, "suma_inicio", 32'(suma_inicio), 32'(m_phase == LAUNCH));
      chk(tag, "ocupado", 32'(ocupado), 32'(m_phase == LAUNCH || m_phase == WAITING));
      chk(tag, "error_timeout", 32'(error_timeout), 32'(m_err));
   endtask

   task automatic step(input string tag, input bit v, input int k, input bit l, input int r);
      @(negedge clk);
      tecla_valida = v; tecla = 4'(k); suma_listo = l; suma_resultado = 15'(r);
      @(posedge clk);
      model_step(v, k, l, r);
      #1;
      if (suma_inicio) pulses++;
      check_all(tag);
      tecla_valida = 1'b0; suma_listo = 1'b0;
   endtask

   task automatic key(input string tag, input int k);
      step(tag, 1'b1, k, 1'b0, 0);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1; tecla_valida = 1'b0; suma_listo = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_all(tag);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset("reset");

      key("b_in_num1", 11);
      key("e_in_num1", 14);
      key("d1", 1); key("d2", 2); key("d3", 3);
      chk("happy", "op1_123", 32'(operando1), 32'd123);
      key("next", 10);
      key("a_in_num2", 10);
      key("d4", 4); key("d5", 5);
      chk("happy", "op2_45", 32'(operando2), 32'd45);
      key("f_in_num2", 15);
      key("equals", 11);
      chk("happy", "inicio_pulse", 32'(suma_inicio), 32'd1);
      key("dig_in_espera", 7);
      key("dig_in_espera2", 3);
      idle("wait3");
      step("listo", 1'b0, 0, 1'b1, 168);
      chk("happy", "resultado_168", 32'(resultado), 32'd168);
      chk("happy", "display_168", 32'(dato_display), 32'd168);
      chk("happy", "one_pulse", 32'(pulses), 32'd1);

      key("b_in_result", 11);
      key("a_in_result", 10);
      key("restart7", 7);
      chk("restart", "op1_7", 32'(operando1), 32'd7);
      chk("restart", "display_7", 32'(dato_display), 32'd7);

      key("clear", 12);
      key("s9", 9); key("s8", 8); key("s7", 7); key("s6", 6); key("s5", 5);
      chk("satur", "op1_9876", 32'(operando1), 32'd9876);

      key("next2", 10); key("r1", 1); key("eq2", 11);
      idle("race_w0"); idle("race_w1");
      step("clear_vs_listo", 1'b1, 12, 1'b1, 99);
      chk("race", "res_dropped", 32'(resultado), 32'd0);
      step("late_listo", 1'b0, 0, 1'b1, 77);

      key("m2", 2); key("mA", 10); key("m3", 3); key("mB", 11); idle("mw");
      do_reset("reset_in_espera");
      step("late_listo2", 1'b0, 0, 1'b1, 55);

`ifdef CTRL_TIMEOUT_EN
      key("t1", 1); key("tA", 10); key("tB", 11);
      for (int i = 0; i < TMO + 4; i++) idle("tmo_wait");
      chk("tmo", "error_set", 32'(error_timeout), 32'd1);
      key("tmo_clear", 12);
      chk("tmo", "error_clr", 32'(error_timeout), 32'd0);
`endif

      for (int i = 0; i < 1500; i++) begin
         int sel, k;
         bit v, l;
         sel = $urandom_range(0, 99);
         if      (sel < 55) k = $urandom_range(0, 9);
         else if (sel < 68) k = 10;
         else if (sel < 82) k = 11;
         else if (sel < 86) k = 12;
         else               k = $urandom_range(13, 15);
         v = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) do_reset("rand_reset");
         else step("random", v, k, l, int'($urandom_range(0, 32767)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_calculadora_teclado.md
Name: control_calculadora_teclado

Overview:
- Sequencer for the keypad calculator datapath: takes one decoded key per strobe and builds two decimal operands in binary.
- Launches the shared adder through a start/done handshake, latches the sum, and selects what the display shows.
- Sits between the keypad decoder (tecla/tecla_valida) and the adder and display blocks; replaces ad hoc load/equal/clear strobes with one ordered flow.

Parameters:
- DIGITOS, 4, maximum decimal digits accepted per operand.
- ANCHO, 14, operand width in bits; must hold 10^DIGITOS-1 (9999 fits in 14).
- TIMEOUT_CICLOS, 64, adder watchdog limit in cycles; used only with CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tecla  in  4  key code: 0x0-0x9 digit, 0xA next operand, 0xB equals, 0xC clear, 0xD-0xF unused
- tecla_valida  in  1  one-cycle strobe; tecla is sampled only while it is high
- operando1  out  ANCHO  first operand register
- operando2  out  ANCHO  second operand register
- suma_inicio  out  1  one-cycle start pulse to the adder
- suma_listo  in  1  adder done; suma_resultado is valid in the same cycle
- suma_resultado  in  ANCHO+1  adder output
- resultado  out  ANCHO+1  latched sum
- dato_display  out  ANCHO+1  value selected for the display
- ocupado  out  1  high in S_INICIO and S_ESPERA
- error_timeout  out  1  sticky watchdog flag (constant 0 without the macro)

Behaviour:
- Reset state: S_NUM1. operando1, operando2, resultado, digit counter, suma_inicio, error_timeout and dato_display all reset to 0.
- States: S_NUM1, S_NUM2, S_INICIO, S_ESPERA, S_RESULT. All outputs are registered.
- Digit key in S_NUM1 or S_NUM2:
  - If the counter is below DIGITOS: active operand <= operand*10 + digit, counter +1.
  - Otherwise the key is ignored, with no wrap and no overflow.
  - Update is visible the cycle after the strobe.
- 0xA:
  - In S_NUM1: go to S_NUM2 and clear the counter. Zero digits entered leaves the operand at 0.
  - Ignored in every other state.
- 0xB:
  - In S_NUM2: go to S_INICIO.
  - suma_inicio is high for exactly the one cycle the FSM is in S_INICIO (strobe at cycle n -> pulse at n+1).
  - Next state is S_ESPERA.
  - 0xB in S_NUM1 or S_RESULT is ignored.
- S_ESPERA: on suma_listo, resultado <= suma_resultado and the FSM goes to S_RESULT; resultado is visible one cycle later. suma_listo in any other state is ignored.
- S_RESULT: a digit key clears both operands and resultado, loads operando1 = digit, sets counter = 1, and goes to S_NUM1. 0xA and 0xB are ignored.
- 0xC in any state:
  - Next cycle: both operands, resultado and counter cleared, state S_NUM1, suma_inicio low.
  - 0xC has priority over a suma_listo in the same cycle; that result is dropped.
  - error_timeout is also cleared.
- Keys 0xD-0xF are ignored everywhere. Keys other than 0xC are ignored in S_INICIO and S_ESPERA.
- dato_display by state:
  - S_NUM1: operando1.
  - S_NUM2, S_INICIO, S_ESPERA: operando2.
  - S_RESULT: resultado.
  - Operands are zero-extended to ANCHO+1.
- rst has priority over all inputs. Reset mid-S_ESPERA aborts, and a late suma_listo is ignored because the FSM is in S_NUM1.

Optional Feature:
- Macro: CTRL_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in S_ESPERA.
  - If TIMEOUT_CICLOS cycles elapse without suma_listo: error_timeout <= 1, both operands cleared, state S_NUM1.
  - error_timeout clears on 0xC or rst.
  - The counter restarts on each entry to S_ESPERA.
- Without the macro: no counter is built, error_timeout is tied to 0, and S_ESPERA waits indefinitely.

Test Plan:
- Happy path: keys 1,2,3,A,4,5,B; adder model raises suma_listo 3 cycles after suma_inicio with 168.
  - Required: operando1=123, operando2=45, one suma_inicio pulse, resultado=168, dato_display=168.
- Digit saturation (DIGITOS=4): keys 9,8,7,6,5 -> operando1=9876, and the fifth key causes no change.
- Clear racing done: in S_ESPERA, drive 0xC strobe and suma_listo in the same cycle -> resultado=0, state S_NUM1, operands 0; a later suma_listo is ignored.
- Ignored keys: B in S_NUM1, 0xE anywhere, A in S_NUM2, digits during S_ESPERA -> no register or state change, no suma_inicio.
- Restart from result: after resultado=168, key 7 -> operando1=7, operando2=0, resultado=0, dato_display=7.
- With CTRL_TIMEOUT_EN and TIMEOUT_CICLOS=64: never assert suma_listo -> error_timeout=1 in the cycle after the limit, state S_NUM1; then key 0xC -> error_timeout=0.
